// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the serial matrix multiplier: loads 18 nibbles,
// flushes, then sweeps os and streams results. Optional: MATSEQ_TIMEOUT_EN.
module matmul_host_sequencer #(
    parameter int DW        = 4,
    parameter int RW        = 10,
    parameter int N_IN      = 18,
    parameter int N_FLUSH   = 9,
    parameter int N_OUT     = 9,
    parameter int IC_HIGH   = 1,
    parameter int IC_LOW    = 1,
    parameter int OS_SETTLE = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          mr_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] mm_i,
    output logic          mm_ic,
    output logic [3:0]    mm_os,
    output logic          mm_en,
    output logic          mm_mr,
    input  logic [RW-1:0] mm_matrix,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [3:0]    out_idx,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_WAIT,
        S_LOAD_HI,
        S_LOAD_LO,
        S_FLUSH_HI,
        S_FLUSH_LO,
        S_SEL,
        S_SETTLE,
        S_OUT
    } state_t;

    state_t        state, state_d;
    logic [7:0]    tmr, tmr_d;
    logic [4:0]    nib, nib_d;
    logic [3:0]    fl, fl_d;
    logic [3:0]    k, k_d;
    logic [DW-1:0] mm_i_d;
    logic [3:0]    mm_os_d;
    logic [RW-1:0] out_data_d;
    logic [3:0]    out_idx_d;
    logic          out_valid_d;
    logic          done_d;
    logic          busy_d;
    logic          in_ready_d;
    logic          mm_ic_d;
    logic          mm_mr_d;
    logic          mm_en_d;
    logic          abort;

`ifdef MATSEQ_TIMEOUT_EN
    logic [15:0] stall, stall_d;
    logic        err_d;
    logic        waiting;

    // Stall watchdog: counts cycles blocked on a stream handshake.
    always_comb begin
        waiting = (state == S_LOAD_WAIT && !in_valid) ||
                  (state == S_OUT && !out_ready);
        abort   = 1'b0;
        stall_d = '0;
        err_d   = err;
        if (waiting) begin
            if (stall == 16'(TIMEOUT - 1)) begin
                abort = 1'b1;
            end else begin
                stall_d = stall + 16'd1;
            end
        end
        if (abort) begin
            err_d = 1'b1;
        end else if (state == S_IDLE && start) begin
            err_d = 1'b0;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!mr_n) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            stall <= stall_d;
            err   <= err_d;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        tmr_d       = tmr;
        nib_d       = nib;
        fl_d        = fl;
        k_d         = k;
        mm_i_d      = mm_i;
        mm_os_d     = mm_os;
        out_data_d  = out_data;
        out_idx_d   = out_idx;
        out_valid_d = out_valid;
        done_d      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    tmr_d   = '0;
                    nib_d   = '0;
                    fl_d    = '0;
                    k_d     = '0;
                    mm_os_d = '0;
                end
            end
            S_CLR: begin
                state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                if (in_valid) begin
                    mm_i_d  = in_data;
                    tmr_d   = '0;
                    state_d = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (tmr == 8'(IC_HIGH - 1)) begin
                    tmr_d   = '0;
                    state_d = S_LOAD_LO;
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            S_LOAD_LO: begin
                if (tmr == 8'(IC_LOW - 1)) begin
                    tmr_d = '0;
                    nib_d = nib + 5'd1;
                    if (nib + 5'd1 < 5'(N_IN)) begin
                        state_d = S_LOAD_WAIT;
                    end else begin
                        mm_i_d  = '0;
                        state_d = S_FLUSH_HI;
                    end
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            S_FLUSH_HI: begin
                if (tmr == 8'(IC_HIGH - 1)) begin
                    tmr_d   = '0;
                    state_d = S_FLUSH_LO;
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            S_FLUSH_LO: begin
                if (tmr == 8'(IC_LOW - 1)) begin
                    tmr_d = '0;
                    fl_d  = fl + 4'd1;
                    if (fl + 4'd1 < 4'(N_FLUSH)) begin
                        state_d = S_FLUSH_HI;
                    end else begin
                        k_d     = '0;
                        mm_os_d = '0;
                        state_d = S_SEL;
                    end
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            S_SEL: begin
                tmr_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (tmr == 8'(OS_SETTLE - 1)) begin
                    tmr_d       = '0;
                    out_data_d  = mm_matrix;
                    out_idx_d   = k;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (k < 4'(N_OUT - 1)) begin
                        k_d     = k + 4'd1;
                        mm_os_d = k + 4'd1;
                        state_d = S_SEL;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_LOAD_WAIT);
        mm_ic_d    = (state_d == S_LOAD_HI) || (state_d == S_FLUSH_HI);
        mm_mr_d    = (state_d == S_CLR) || abort;
        mm_en_d    = busy_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!mr_n) begin
            state     <= S_IDLE;
            tmr       <= '0;
            nib       <= '0;
            fl        <= '0;
            k         <= '0;
            mm_i      <= '0;
            mm_ic     <= 1'b0;
            mm_os     <= '0;
            mm_en     <= 1'b0;
            mm_mr     <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            tmr       <= tmr_d;
            nib       <= nib_d;
            fl        <= fl_d;
            k         <= k_d;
            mm_i      <= mm_i_d;
            mm_ic     <= mm_ic_d;
            mm_os     <= mm_os_d;
            mm_en     <= mm_en_d;
            mm_mr     <= mm_mr_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_idx   <= out_idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer with a behavioural
// multiplier model (C = A x B, A and B row-major 3x3 nibbles).
module tb_matmul_host_sequencer;

    logic       clk = 1'b0;
    logic       mr_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] mm_i;
    logic       mm_ic;
    logic [3:0] mm_os;
    logic       mm_en;
    logic       mm_mr;
    logic [9:0] mm_matrix;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic [3:0] out_idx;
    logic       err;

`ifdef MATSEQ_TIMEOUT_EN
    localparam int STALL = 12;
`else
    localparam int STALL = 20;
`endif

    always #5 clk = ~clk;

    matmul_host_sequencer #(.TIMEOUT(16)) u_dut (
        .clk       (clk),
        .mr_n      (mr_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_i      (mm_i),
        .mm_ic     (mm_ic),
        .mm_os     (mm_os),
        .mm_en     (mm_en),
        .mm_mr     (mm_mr),
        .mm_matrix (mm_matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] nibs [18] = '{4'd1, 4'd4, 4'd5, 4'd4, 4'd5, 4'd6,
                              4'd0, 4'd0, 4'd0, 4'd10, 4'd11, 4'd7,
                              4'd13, 4'd14, 4'd9, 4'd2, 4'd3, 4'd4};
    int exp_c [9] = '{72, 82, 63, 117, 132, 97, 0, 0, 0};

    // multiplier model and protocol monitors
    logic [3:0] nb [18] = '{default: 4'd0};
    int         nb_cnt = 0;
    logic       ic_prev = 1'b0;
    logic [3:0] i_at_rise = 4'd0;
    logic       clr_mon = 1'b0;
    int         ic_edges = 0;
    int         mr_cycles = 0;
    int         done_pulses = 0;
    int         i_glitches = 0;
    int         busy_cycles = 0;

    always @(posedge clk) begin
        ic_prev <= mm_ic;
        if (mm_mr === 1'b1) begin
            nb_cnt <= 0;
        end else if (mm_ic === 1'b1 && ic_prev == 1'b0 && nb_cnt < 18) begin
            nb[nb_cnt] <= mm_i;
            nb_cnt     <= nb_cnt + 1;
        end
        if (mm_ic === 1'b1 && ic_prev == 1'b0) i_at_rise <= mm_i;
        if (clr_mon) begin
            ic_edges    <= 0;
            mr_cycles   <= 0;
            done_pulses <= 0;
            i_glitches  <= 0;
            busy_cycles <= 0;
        end else begin
            if (mm_ic === 1'b1 && ic_prev == 1'b0) ic_edges <= ic_edges + 1;
            if (mm_mr === 1'b1) mr_cycles <= mr_cycles + 1;
            if (done === 1'b1) done_pulses <= done_pulses + 1;
            if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
            if (ic_prev == 1'b1 && mm_i !== i_at_rise) i_glitches <= i_glitches + 1;
        end
    end

    always_comb begin
        mm_matrix = '0;
        if (mm_os < 4'd9) begin
            for (int j = 0; j < 3; j++) begin
                mm_matrix = mm_matrix +
                    10'(nb[(int'(mm_os) / 3) * 3 + j]) *
                    10'(nb[9 + j * 3 + int'(mm_os) % 3]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one nibble after `gap` idle cycles; returns just after the handshake edge.
    task automatic feed_nibble(input logic [3:0] d, input int gap);
        int n;
        repeat (gap) cyc();
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) check("in_ready_wait", n, 0);
        cyc();
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic run_job(input int gap_max, input bit stall3, input bit poke);
        int  got;
        int  n;
        bit  hold_ok;
        bit  stalled;
        clr_mon = 1'b1;
        cyc();
        clr_mon = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_mm_mr", mm_mr, 1);
        check("clr_mm_en", mm_en, 1);
        check("clr_err", err, 0);
        for (int i = 0; i < 18; i++) begin
            feed_nibble(nibs[i], gap_max > 0 ? $urandom_range(0, gap_max) : 0);
        end
        if (poke) begin
            cyc();
            cyc();
            check("flush_ic", mm_ic, 1);
            start    = 1'b1;
            in_valid = 1'b1;
            in_data  = 4'd9;
            for (int i = 0; i < 4; i++) begin
                cyc();
                check("flush_in_ready", in_ready, 0);
            end
            start    = 1'b0;
            in_valid = 1'b0;
            in_data  = 4'd0;
        end
        got       = 0;
        n         = 0;
        stalled   = 1'b0;
        out_ready = 1'b1;
        while (got < 9 && n < 400) begin
            if (out_valid === 1'b1) begin
                if (stall3 && out_idx == 4'd3 && !stalled) begin
                    out_ready = 1'b0;
                    stalled   = 1'b1;
                    hold_ok   = 1'b1;
                    repeat (STALL) begin
                        cyc();
                        if (out_data !== 10'd117 || out_idx !== 4'd3 ||
                            mm_os !== 4'd3 || out_valid !== 1'b1)
                            hold_ok = 1'b0;
                    end
                    check("stall_data", out_data, 117);
                    check("stall_idx", out_idx, 3);
                    check("stall_os", mm_os, 3);
                    check("stall_hold", hold_ok, 1);
                    out_ready = 1'b1;
                end
                check($sformatf("res%0d", got), out_data, exp_c[got]);
                check($sformatf("idx%0d", got), out_idx, got);
                got++;
            end
            cyc();
            n++;
        end
        if (got < 9) check("out_count", got, 9);
        cyc();
        cyc();
        check("done_pulses", done_pulses, 1);
        check("ic_edges", ic_edges, 27);
        check("mr_cycles", mr_cycles, 1);
        check("mm_i_stable", i_glitches, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 0);
        check("end_os", mm_os, 8);
        if (gap_max == 0 && !stall3) check("job_cycles", busy_cycles, 109);
    endtask

    initial begin
        int n;
        int wait_cnt;
        mr_n      = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        repeat (2) cyc();

        check("rst_mm_mr", mm_mr, 1);
        check("rst_mm_ic", mm_ic, 0);
        check("rst_mm_i", mm_i, 0);
        check("rst_mm_os", mm_os, 0);
        check("rst_mm_en", mm_en, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        mr_n = 1'b1;
        cyc();
        check("idle_mm_mr", mm_mr, 0);

        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("idle_in_ready", in_ready, 0);
            check("idle_busy", busy, 0);
        end
        in_valid = 1'b0;
        in_data  = 4'd0;

        run_job(0, 1'b0, 1'b0);
        run_job(5, 1'b0, 1'b0);
        run_job(0, 1'b1, 1'b0);

        clr_mon = 1'b1;
        cyc();
        clr_mon = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 10; i++) feed_nibble(nibs[i], 0);
        check("mid_ic_high", mm_ic, 1);
        mr_n = 1'b0;
        cyc();
        check("mid_rst_ic", mm_ic, 0);
        check("mid_rst_mr", mm_mr, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        mr_n = 1'b1;
        cyc();
        run_job(0, 1'b0, 1'b0);

        run_job(0, 1'b0, 1'b1);

`ifdef MATSEQ_TIMEOUT_EN
        clr_mon = 1'b1;
        cyc();
        clr_mon = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) feed_nibble(nibs[i], 0);
        n        = 0;
        wait_cnt = 0;
        while (busy === 1'b1 && n < 200) begin
            if (in_ready === 1'b1) wait_cnt++;
            cyc();
            n++;
        end
        check("to_stall_cycles", wait_cnt, 16);
        check("to_err", err, 1);
        check("to_mm_mr", mm_mr, 1);
        check("to_in_ready", in_ready, 0);
        check("to_out_valid", out_valid, 0);
        cyc();
        check("to_mr_drop", mm_mr, 0);
        check("to_err_sticky", err, 1);
        cyc();
        check("to_no_done", done_pulses, 0);
        run_job(0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
